// File: rtl/leaf_stream_arbiter.sv
// Round-robin arbiter sharing one leaf_interface user->interface port between NUM_REQ
// ap_vld/ap_ack operator streams, with bounded bursts and a registered, source-tagged output word.
module leaf_stream_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 8
) (
  input  logic                            clk_user,
  input  logic                            reset_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_dout,
  output logic [REQ_BITS-1:0]             out_port,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic                            busy
);

  // state   | meaning
  // S_IDLE  | no holder; pick next valid stream after 'last' (one-cycle bubble)
  // S_GRANT | 'grant' may move words until burst limit or it drops req_vld
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam int BURST_BITS = $clog2(MAX_BURST) + 1;
  localparam logic [BURST_BITS-1:0] BURST_LAST = BURST_BITS'(MAX_BURST - 1);

  logic [0:0]              state;
  logic [REQ_BITS-1:0]     grant;
  logic [REQ_BITS-1:0]     last;
  logic [BURST_BITS-1:0]   burst_cnt;
  logic [REQ_BITS-1:0]     pick_idx;
  logic [REQ_BITS-1:0]     cand;
  logic                    pick_found;
  logic                    out_free;
  logic                    holder_vld;
  logic                    xfer;
  logic [PAYLOAD_BITS-1:0] grant_word;

  // Rotating priority: the stream just after the previous holder is scanned first.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = REQ_BITS'((int'(last) + k) % NUM_REQ);
      if (!pick_found && req_vld[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign out_free   = !out_vld || out_ack;
  assign holder_vld = req_vld[grant];
  assign xfer       = (state == S_GRANT) && holder_vld && out_free;
  assign grant_word = req_din[int'(grant)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign busy       = (state == S_GRANT) || out_vld;

  always_comb begin
    req_ack = '0;
    if (xfer) req_ack[grant] = 1'b1;
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      last      <= REQ_BITS'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A stalled holder keeps the grant without consuming burst budget.
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BURST_LAST) begin
              last  <= grant;
              state <= S_IDLE;
            end
          end else if (!holder_vld) begin
            last  <= grant;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      out_vld  <= 1'b0;
      out_dout <= '0;
      out_port <= '0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_dout <= grant_word;
      out_port <= grant;
    end else if (out_ack) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Directed and random bench for leaf_stream_arbiter: stream sources model ap_vld/ap_ack,
// a negedge monitor logs every downstream word for per-test checking.
module tb_leaf_stream_arbiter;

  logic         clk_user = 1'b0;
  logic         reset_n  = 1'b0;
  logic [127:0] req_din;
  logic [3:0]   req_vld;
  logic [3:0]   req_ack;
  logic [31:0]  out_dout;
  logic [1:0]   out_port;
  logic         out_vld;
  logic         out_ack;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
    int          cyc;
  } ent_t;
  ent_t log_q[$];

  logic [31:0] src_next[4];
  int          src_sent[4];
  int          src_limit[4];
  logic [3:0]  src_en;
  logic        rnd_mode;
  logic [3:0]  acc_q;
  logic        src_pend;

  leaf_stream_arbiter #(
    .NUM_REQ(4), .REQ_BITS(2), .PAYLOAD_BITS(32), .MAX_BURST(8)
  ) dut (
    .clk_user(clk_user), .reset_n(reset_n),
    .req_din(req_din), .req_vld(req_vld), .req_ack(req_ack),
    .out_dout(out_dout), .out_port(out_port), .out_vld(out_vld),
    .out_ack(out_ack), .busy(busy)
  );

  always #5 clk_user = ~clk_user;

  always @(posedge clk_user) cyc <= cyc + 1;

  always @(negedge clk_user) begin
    acc_q <= req_vld & req_ack;
    if (reset_n && out_vld && out_ack) log_q.push_back('{out_port, out_dout, cyc});
  end

  // A source holds its word and vld until accepted, then advances to the next word.
  always @(posedge clk_user) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      src_pend = req_vld[i] && !acc_q[i];
      if (acc_q[i]) begin
        src_next[i] = src_next[i] + 32'd1;
        src_sent[i] = src_sent[i] + 1;
      end
      if (!src_pend)
        req_vld[i] = src_en[i] && (src_sent[i] < src_limit[i]) &&
                     (!rnd_mode || $urandom_range(0, 3) != 0);
      req_din[i*32 +: 32] = src_next[i];
    end
  end

  function automatic logic [31:0] base_of(int i);
    return 32'((i + 1) << 20);
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_next[i]  = base_of(i);
      src_sent[i]  = 0;
      src_limit[i] = 1 << 30;
    end
    log_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk_user); #1;
    reset_n  = 1'b0;
    src_en   = 4'h0;
    rnd_mode = 1'b0;
    out_ack  = 1'b0;
    req_vld  = 4'h0;
    repeat (2) @(posedge clk_user);
    #1;
    clear_sources();
    reset_n = 1'b1;
  endtask

  task automatic wait_log(int n, int budget);
    for (int k = 0; k < budget && log_q.size() < n; k++) begin
      @(posedge clk_user); #1;
    end
    if (log_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_log: got %0d words, required %0d within %0d cycles", log_q.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_cmp++; if (req_ack !== 4'h0) begin n_bad++; $display("FAIL reset_req_ack: got %h want 0", req_ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_dout !== 32'h0) begin n_bad++; $display("FAIL reset_out_dout: got %h want 0", out_dout); end
    n_cmp++; if (out_port !== 2'd0) begin n_bad++; $display("FAIL reset_out_port: got %0d want 0", out_port); end
  endtask

  task automatic test_single_stream();
    int t0;
    do_reset();
    out_ack      = 1'b1;
    src_next[2]  = 32'h100;
    src_limit[2] = 5;
    src_en[2]    = 1'b1;
    t0 = cyc;
    wait_log(5, 50);
    if (log_q.size() >= 5) begin
      n_cmp++;
      if (log_q[0].cyc - t0 != 2) begin
        n_bad++; $display("FAIL single_latency: got %0d cycles want 2", log_q[0].cyc - t0);
      end
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (log_q[k].port !== 2'd2 || log_q[k].data !== 32'h100 + 32'(k)) begin
          n_bad++; $display("FAIL single_word%0d: got port %0d data %h want port 2 data %h",
                            k, log_q[k].port, log_q[k].data, 32'h100 + 32'(k));
        end
        if (k > 0) begin
          n_cmp++;
          if (log_q[k].cyc - log_q[k-1].cyc != 1) begin
            n_bad++; $display("FAIL single_gap%0d: got %0d want 1", k, log_q[k].cyc - log_q[k-1].cyc);
          end
        end
      end
    end
    repeat (5) @(posedge clk_user);
    @(negedge clk_user);
    n_cmp++; if (busy !== 1'b0 || out_vld !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got busy %b out_vld %b want 0 0", busy, out_vld);
    end
    n_cmp++; if (log_q.size() != 5) begin
      n_bad++; $display("FAIL single_count: got %0d words want 5", log_q.size());
    end
  endtask

  task automatic test_round_robin();
    int p;
    logic [31:0] d;
    do_reset();
    out_ack = 1'b1;
    src_en  = 4'hF;
    wait_log(40, 200);
    if (log_q.size() >= 40) begin
      for (int k = 0; k < 40; k++) begin
        p = (k / 8) % 4;
        d = base_of(p) + 32'((k / 32) * 8 + (k % 8));
        n_cmp++;
        if (log_q[k].port !== 2'(p) || log_q[k].data !== d) begin
          n_bad++; $display("FAIL rr_word%0d: got port %0d data %h want port %0d data %h",
                            k, log_q[k].port, log_q[k].data, p, d);
        end
        if (k > 0) begin
          n_cmp++;
          if (log_q[k].cyc - log_q[k-1].cyc != ((k % 8 == 0) ? 2 : 1)) begin
            n_bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k,
                              log_q[k].cyc - log_q[k-1].cyc, (k % 8 == 0) ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ack = 1'b1;
    src_en  = 4'b0011;
    wait_log(3, 50);
    n_cmp++; if (log_q.size() != 3) begin
      n_bad++; $display("FAIL bp_pre_count: got %0d want 3", log_q.size());
    end
    out_ack = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_user);
      n_cmp++;
      if (req_ack !== 4'h0 || out_vld !== 1'b1 || out_dout !== base_of(0) + 32'd3 || out_port !== 2'd0) begin
        n_bad++; $display("FAIL bp_stall%0d: got ack %h vld %b data %h port %0d want 0 1 %h 0",
                          s, req_ack, out_vld, out_dout, out_port, base_of(0) + 32'd3);
      end
      @(posedge clk_user); #1;
    end
    out_ack = 1'b1;
    wait_log(9, 100);
    if (log_q.size() >= 9) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (log_q[k].port !== 2'd0 || log_q[k].data !== base_of(0) + 32'(k)) begin
          n_bad++; $display("FAIL bp_word%0d: got port %0d data %h want port 0 data %h",
                            k, log_q[k].port, log_q[k].data, base_of(0) + 32'(k));
        end
      end
      n_cmp++;
      if (log_q[8].port !== 2'd1 || log_q[8].data !== base_of(1)) begin
        n_bad++; $display("FAIL bp_next_burst: got port %0d data %h want port 1 data %h",
                          log_q[8].port, log_q[8].data, base_of(1));
      end
    end
  endtask

  task automatic test_early_release();
    logic [1:0]  ep;
    logic [31:0] ed;
    do_reset();
    out_ack      = 1'b1;
    src_limit[1] = 3;
    src_en       = 4'b1010;
    wait_log(13, 200);
    src_limit[1] = 5;
    wait_log(22, 200);
    if (log_q.size() >= 22) begin
      for (int k = 0; k < 22; k++) begin
        if (k < 3)       begin ep = 2'd1; ed = base_of(1) + 32'(k); end
        else if (k < 19) begin ep = 2'd3; ed = base_of(3) + 32'(k - 3); end
        else if (k < 21) begin ep = 2'd1; ed = base_of(1) + 32'(k - 16); end
        else             begin ep = 2'd3; ed = base_of(3) + 32'd16; end
        n_cmp++;
        if (log_q[k].port !== ep || log_q[k].data !== ed) begin
          n_bad++; $display("FAIL early_word%0d: got port %0d data %h want port %0d data %h",
                            k, log_q[k].port, log_q[k].data, ep, ed);
        end
      end
      n_cmp++;
      if (log_q[3].cyc - log_q[2].cyc != 3) begin
        n_bad++; $display("FAIL early_handover: got %0d cycles want 3", log_q[3].cyc - log_q[2].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    out_ack = 1'b1;
    src_en  = 4'hF;
    wait_log(12, 100);
    n_cmp++; if (out_vld !== 1'b1 || out_port !== 2'd1) begin
      n_bad++; $display("FAIL midrst_pre: got vld %b port %0d want 1 1", out_vld, out_port);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vld !== 1'b0 || req_ack !== 4'h0 || busy !== 1'b0 || out_dout !== 32'h0 || out_port !== 2'd0) begin
      n_bad++; $display("FAIL midrst_clear: got vld %b ack %h busy %b data %h port %0d want all 0",
                        out_vld, req_ack, busy, out_dout, out_port);
    end
    log_q.delete();
    repeat (2) @(posedge clk_user);
    #1;
    reset_n = 1'b1;
    wait_log(1, 50);
    if (log_q.size() >= 1) begin
      n_cmp++;
      if (log_q[0].port !== 2'd0) begin
        n_bad++; $display("FAIL midrst_first_grant: got port %0d want 0", log_q[0].port);
      end
    end
  endtask

  task automatic test_random();
    int          wait_c[4];
    int          stall_c[4];
    int          rcv[4];
    logic [31:0] exp_d[4];
    logic        prev_hold;
    logic [31:0] prev_dout;
    logic [1:0]  prev_port;
    do_reset();
    for (int i = 0; i < 4; i++) begin wait_c[i] = 0; stall_c[i] = 0; rcv[i] = 0; exp_d[i] = base_of(i); end
    prev_hold = 1'b0; prev_dout = '0; prev_port = '0;
    rnd_mode = 1'b1;
    src_en   = 4'hF;
    out_ack  = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk_user);
      n_cmp++;
      if ($countones(req_ack) > 1 || (req_ack & ~req_vld) != 4'h0) begin
        n_bad++; $display("FAIL rnd_onehot c%0d: got ack %h vld %h want one-hot-or-zero subset", c, req_ack, req_vld);
      end
      if (prev_hold) begin
        n_cmp++;
        if (out_vld !== 1'b1 || out_dout !== prev_dout || out_port !== prev_port) begin
          n_bad++; $display("FAIL rnd_hold c%0d: got vld %b data %h port %0d want 1 %h %0d",
                            c, out_vld, out_dout, out_port, prev_dout, prev_port);
        end
      end
      prev_hold = out_vld && !out_ack;
      prev_dout = out_dout;
      prev_port = out_port;
      for (int i = 0; i < 4; i++) begin
        if (req_vld[i] && !req_ack[i]) begin
          wait_c[i]++;
          if (!out_ack) stall_c[i]++;
          n_cmp++;
          if (wait_c[i] > 3 * 9 + stall_c[i] + 2) begin
            n_bad++; $display("FAIL rnd_starve s%0d c%0d: got wait %0d want <= %0d",
                              i, c, wait_c[i], 3 * 9 + stall_c[i] + 2);
          end
        end else begin
          wait_c[i] = 0; stall_c[i] = 0;
        end
      end
      @(posedge clk_user); #1;
      out_ack = ($urandom_range(0, 3) != 0);
    end
    src_en  = 4'h0;
    out_ack = 1'b1;
    repeat (100) @(posedge clk_user);
    @(negedge clk_user);
    n_cmp++; if (req_vld !== 4'h0 || out_vld !== 1'b0) begin
      n_bad++; $display("FAIL rnd_drain: got vld %h out_vld %b want 0 0", req_vld, out_vld);
    end
    foreach (log_q[k]) begin
      n_cmp++;
      if (log_q[k].data !== exp_d[log_q[k].port]) begin
        n_bad++; $display("FAIL rnd_order w%0d: got port %0d data %h want %h",
                          k, log_q[k].port, log_q[k].data, exp_d[log_q[k].port]);
      end
      exp_d[log_q[k].port] = log_q[k].data + 32'd1;
      rcv[log_q[k].port]++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rcv[i] != src_sent[i] || src_sent[i] == 0) begin
        n_bad++; $display("FAIL rnd_count s%0d: got %0d received want %0d accepted (nonzero)", i, rcv[i], src_sent[i]);
      end
    end
  endtask

  initial begin
    req_vld  = 4'h0;
    req_din  = '0;
    out_ack  = 1'b0;
    src_en   = 4'h0;
    rnd_mode = 1'b0;
    acc_q    = 4'h0;
    clear_sources();
    #3;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
